output_port_bank: RTL and testbench
===================================

Name: output_port_bank

Overview:
- Parametrised bank of memory-mapped output ports on the processor's data bus; the next generation of the fixed two-port output block.
- Each port is reachable in four address windows (write, bit-set, bit-clear, bit-toggle), so software can change single bits without read-modify-write.
- Ports can run in pulse mode: they auto-clear after a programmable number of cycles.
- A one-cycle update strobe per port tells downstream logic that a port was written.

Parameters:
- DATA_W, 8, port and bus data width.
- ADDR_W, 8, bus address width.
- NUM_PORTS, 4, number of output ports; range 1..DATA_W.
- BASE_ADDR, 8'hE0, first address of the bank. BASE_ADDR + 4*NUM_PORTS must be less than 2^ADDR_W.
- PULSE_CYCLES, 4, cycles a pulse-mode port holds its value after a write; must be at least 1.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- address  input  ADDR_W  bus address
- data_in  input  DATA_W  bus write data
- write  input  1  write strobe, sampled on a rising edge
- read  input  1  read strobe (used only with the optional feature)
- port_out  output  NUM_PORTS*DATA_W  port registers; port i is in bits [i*DATA_W +: DATA_W]
- port_update  output  NUM_PORTS  one-cycle strobe per port
- data_out  output  DATA_W  registered read data
- read_valid  output  1  data_out qualifier

Behaviour:
- Reset is clock, active low, asynchronous. While asserted: port_out, port_update, data_out, read_valid, the control register and all timers are 0, immediately and regardless of the clock. This includes reset in the middle of a pulse.
- Address map, with off = address - BASE_ADDR and i the port number:
  - off 0..N-1: WRITE, port[i] <= data_in
  - off N..2N-1: SET, port[i] <= port[i] | data_in
  - off 2N..3N-1: CLR, port[i] <= port[i] & ~data_in
  - off 3N..4N-1: TGL, port[i] <= port[i] ^ data_in
  - off 4N: CTRL register; bits [N-1:0] are the per-port pulse-enable bits, upper bits read 0
  - any other address: writes ignored, reads return 0
- Write latency: the new port value is visible on port_out after the rising edge where write=1. No wait states.
- port_update[i] is high for exactly the cycle in which a bus write to port i first appears on port_out. It fires for every write, including a write of an unchanged value. A write to CTRL or an auto-clear does not fire it.
- Pulse mode, for port i with CTRL[i]=1:
  - Any bus write to port i loads timer[i] with PULSE_CYCLES.
  - The timer decrements each cycle while non-zero.
  - When the timer goes from 1 to 0, port[i] is cleared on that same edge.
  - Net effect: the written value is visible for exactly PULSE_CYCLES cycles.
- Timer width is $clog2(PULSE_CYCLES+1).
- Boundary cases:
  - A write during an active pulse reloads the timer to PULSE_CYCLES; the pulse is extended, not queued.
  - A write on the same edge as expiry: the write wins and the timer is reloaded.
  - Clearing CTRL[i] mid-pulse zeroes timer[i]; port[i] keeps its current value.
  - Setting CTRL[i] does not start a timer; only a subsequent write to the port does.
  - A port in pulse mode that is written with 0 still loads the timer; the strobe still fires.

Optional Feature:
- Macro OUTPUT_PORT_BANK_READBACK_EN.
- Defined:
  - A read in the WRITE window or at the CTRL address returns that register on data_out one cycle later, with read_valid high for one cycle.
  - Reads in the SET, CLR and TGL windows, and at unmapped addresses, return 0 with read_valid high.
  - A read and a write to the same register in the same cycle return the pre-write value.
- Undefined: data_out and read_valid are tied to 0; the read input is unused.

Decomposition:
- Package outport_pkg:
  - op enum: OP_WRITE, OP_SET, OP_CLR, OP_TGL, OP_CTRL, OP_NONE
  - address-decode function returning {op, port index}
  - localparams for window offsets
- Sub-module outport_channel, instantiated NUM_PORTS times:
  - holds one port register, its pulse timer and its update strobe
  - takes the decoded op, data_in and its pulse-enable bit as inputs
- The top level holds the decoder, the CTRL register and the readback mux.

Test Plan (defaults: WRITE E0-E3, SET E4-E7, CLR E8-EB, TGL EC-EF, CTRL F0):
- Reset, then write E1=A5: port1=A5 on the next edge; port_update=4'b0010 for exactly one cycle; all other ports stay 00.
- Starting from port1=A5: SET E5=0F gives AF; then CLR E9=A0 gives 0F; then TGL ED=FF gives F0. port_update[1] pulses once per write.
- Write CTRL F0=01, then E0=3C: port0=3C for 4 cycles, then 00, with no strobe on the clear. Repeat, rewriting E0=3C two cycles in: the value holds for 4 cycles after the second write.
- Write F1=DF and F5=11: no port or CTRL change; port_update stays 0.
- With READBACK_EN: read E1 returns A5 with read_valid one cycle later; read F0 returns 01; a same-cycle write E1=00 and read E1 returns A5.
- Assert reset mid-pulse (timer=2): all outputs and timers are 0 immediately; after release, port0 stays 00.

Source files
------------

// File: rtl/outport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : outport_pkg
//  Description : Shared types and the address decoder for the output port
//                bank. Each port appears in four consecutive windows of
//                NUM_PORTS addresses (write, set, clear, toggle), followed
//                by a single control register address.
//  Revision    : 1.0 - initial release
// ============================================================================
package outport_pkg;

    // Bus operation selected by the current address
    typedef enum logic [2:0] {
        OP_WRITE = 3'd0,
        OP_SET   = 3'd1,
        OP_CLR   = 3'd2,
        OP_TGL   = 3'd3,
        OP_CTRL  = 3'd4,
        OP_NONE  = 3'd5
    } op_e;

    // Window numbers; window k starts at offset k*NUM_PORTS
    localparam int unsigned WIN_WRITE = 0;
    localparam int unsigned WIN_SET   = 1;
    localparam int unsigned WIN_CLR   = 2;
    localparam int unsigned WIN_TGL   = 3;
    localparam int unsigned WIN_CTRL  = 4;

    // Width of the decoded port index (covers any NUM_PORTS <= DATA_W)
    localparam int IDX_W = 16;

    typedef struct packed {
        op_e               op;
        logic [IDX_W-1:0]  idx;
    } decode_t;

    // Map a bus address onto {operation, port index}
    function automatic decode_t decode_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] nports
    );
        decode_t     d;
        logic [31:0] off;
        d.op  = OP_NONE;
        d.idx = '0;
        off   = addr - base;
        if (addr >= base) begin
            if (off < nports * (WIN_WRITE + 1)) begin
                d.op  = OP_WRITE;
                d.idx = IDX_W'(off);
            end else if (off < nports * (WIN_SET + 1)) begin
                d.op  = OP_SET;
                d.idx = IDX_W'(off - nports * WIN_SET);
            end else if (off < nports * (WIN_CLR + 1)) begin
                d.op  = OP_CLR;
                d.idx = IDX_W'(off - nports * WIN_CLR);
            end else if (off < nports * (WIN_TGL + 1)) begin
                d.op  = OP_TGL;
                d.idx = IDX_W'(off - nports * WIN_TGL);
            end else if (off == nports * WIN_CTRL) begin
                d.op  = OP_CTRL;
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/outport_channel.sv
`default_nettype none
// ============================================================================
//  Module      : outport_channel
//  Description : One output port: data register, pulse-mode auto-clear timer
//                and the one-cycle update strobe. A bus write always wins
//                over timer expiry on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module outport_channel
    import outport_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int PULSE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  op_e               op,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pulse_en,
    output logic [DATA_W-1:0] port_value,
    output logic              update
);

    localparam int TIMER_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [TIMER_W-1:0] C_PULSE_LOAD = TIMER_W'(PULSE_CYCLES);
    localparam logic [TIMER_W-1:0] C_TIMER_ONE  = TIMER_W'(1);

    logic [DATA_W-1:0]  r_port;
    logic [DATA_W-1:0]  w_next_port;
    logic [TIMER_W-1:0] r_timer;
    logic               r_update;

    // Value the port takes on a bus write, by window
    always_comb begin
        w_next_port = data_in;
        case (op)
            OP_SET:  w_next_port = r_port | data_in;
            OP_CLR:  w_next_port = r_port & ~data_in;
            OP_TGL:  w_next_port = r_port ^ data_in;
            default: w_next_port = data_in;
        endcase
    end

    // Port register, pulse timer and update strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_port   <= '0;
            r_timer  <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= write_en;
            if (write_en) begin
                r_port  <= w_next_port;
                r_timer <= pulse_en ? C_PULSE_LOAD : '0;
            end else if (!pulse_en) begin
                // Leaving pulse mode freezes the port at its current value
                r_timer <= '0;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - C_TIMER_ONE;
                if (r_timer == C_TIMER_ONE) begin
                    r_port <= '0;
                end
            end
        end
    end

    assign port_value = r_port;
    assign update     = r_update;

endmodule
`default_nettype wire

// File: rtl/output_port_bank.sv
`default_nettype none
// ============================================================================
//  Module      : output_port_bank
//  Description : Bank of NUM_PORTS memory-mapped output ports with write,
//                bit-set, bit-clear and bit-toggle windows, a control
//                register of per-port pulse-mode enables, and per-port
//                update strobes.
//                Optional readback path: OUTPUT_PORT_BANK_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_port_bank
    import outport_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter int                NUM_PORTS    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 8'hE0,
    parameter int                PULSE_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        write,
    input  logic                        read,
    output logic [NUM_PORTS*DATA_W-1:0] port_out,
    output logic [NUM_PORTS-1:0]        port_update,
    output logic [DATA_W-1:0]           data_out,
    output logic                        read_valid
);

    decode_t                w_dec;
    logic                   w_port_access;
    logic [NUM_PORTS-1:0]   r_ctrl;
    logic [NUM_PORTS-1:0]   w_ctrl_next;

    assign w_dec = decode_addr(32'(address), 32'(BASE_ADDR), 32'(NUM_PORTS));

    assign w_port_access = write && (w_dec.op == OP_WRITE || w_dec.op == OP_SET ||
                                     w_dec.op == OP_CLR   || w_dec.op == OP_TGL);

    // Channels see the post-write CTRL value so clearing a bit stops the
    // timer on the same edge, before it can expire
    assign w_ctrl_next = (write && w_dec.op == OP_CTRL) ? data_in[NUM_PORTS-1:0] : r_ctrl;

    // Control register holding the pulse-enable bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl_next;
        end
    end

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            outport_channel #(
                .DATA_W       (DATA_W),
                .PULSE_CYCLES (PULSE_CYCLES)
            ) u_channel (
                .clock      (clock),
                .reset      (reset),
                .write_en   (w_port_access && (w_dec.idx == IDX_W'(i))),
                .op         (w_dec.op),
                .data_in    (data_in),
                .pulse_en   (w_ctrl_next[i]),
                .port_value (port_out[i*DATA_W +: DATA_W]),
                .update     (port_update[i])
            );
        end
    endgenerate

`ifdef OUTPUT_PORT_BANK_READBACK_EN
    logic [DATA_W-1:0] w_rd_value;
    logic [DATA_W-1:0] r_data_out;
    logic              r_read_valid;

    // Readback mux; only WRITE window and CTRL return register contents
    always_comb begin
        w_rd_value = '0;
        if (w_dec.op == OP_WRITE) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_dec.idx == IDX_W'(i)) begin
                    w_rd_value = port_out[i*DATA_W +: DATA_W];
                end
            end
        end else if (w_dec.op == OP_CTRL) begin
            w_rd_value = DATA_W'(r_ctrl);
        end
    end

    // Registered read data; samples pre-write values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= read;
            r_data_out   <= read ? w_rd_value : '0;
        end
    end

    assign data_out   = r_data_out;
    assign read_valid = r_read_valid;
`else
    logic w_unused_read;
    assign w_unused_read = read;
    assign data_out      = '0;
    assign read_valid    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_port_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_port_bank
//  Description : Self-checking bench for output_port_bank (default params).
//                Directed vector table, hand-written pulse/reset sequences,
//                and random traffic against a window-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_bank;

    localparam int C_PULSE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  address = '0;
    logic [7:0]  data_in = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] port_out;
    logic [3:0]  port_update;
    logic [7:0]  data_out;
    logic        read_valid;

    int n_checks = 0;
    int n_pass   = 0;

    output_port_bank #(
        .DATA_W       (8),
        .ADDR_W       (8),
        .NUM_PORTS    (4),
        .BASE_ADDR    (8'hE0),
        .PULSE_CYCLES (C_PULSE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .write       (write),
        .read        (read),
        .port_out    (port_out),
        .port_update (port_update),
        .data_out    (data_out),
        .read_valid  (read_valid)
    );

    always #5 clock = ~clock;

    // Reference model state: port values, cycles left in the pulse, control
    logic [7:0] m_port [4];
    int         m_rem  [4];
    logic [3:0] m_ctrl;
    logic [3:0] m_upd;
    logic [7:0] m_dout;
    logic       m_rv;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_port[i] = '0;
            m_rem[i]  = 0;
        end
        m_ctrl = '0; m_upd = '0; m_dout = '0; m_rv = 1'b0;
    endtask

    // One rising edge of the bank, computed from the address map rules
    task automatic model_step(input logic [7:0] a, input logic [7:0] d, input logic w, input logic r);
        int off, win, idx;
        off = int'(a) - 'hE0;
        m_rv = 1'b0; m_dout = '0;
`ifdef OUTPUT_PORT_BANK_READBACK_EN
        if (r) begin
            m_rv = 1'b1;
            if (off >= 0 && off < 4) m_dout = m_port[off];
            else if (off == 16)      m_dout = {4'b0, m_ctrl};
        end
`endif
        if (w && off == 16) begin
            m_ctrl = d[3:0];
            for (int i = 0; i < 4; i++) if (!m_ctrl[i]) m_rem[i] = 0;
        end
        win = -1; idx = -1;
        if (w && off >= 0 && off < 16) begin
            win = off / 4;
            idx = off % 4;
        end
        for (int i = 0; i < 4; i++) begin
            m_upd[i] = 1'b0;
            if (idx == i) begin
                case (win)
                    0: m_port[i] = d;
                    1: m_port[i] = m_port[i] | d;
                    2: m_port[i] = m_port[i] & ~d;
                    default: m_port[i] = m_port[i] ^ d;
                endcase
                m_upd[i] = 1'b1;
                m_rem[i] = m_ctrl[i] ? C_PULSE : 0;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_port[i] = '0;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model(input string name);
        check({name, ".port_out"}, 64'(port_out),
              64'({m_port[3], m_port[2], m_port[1], m_port[0]}));
        check({name, ".port_update"}, 64'(port_update), 64'(m_upd));
        check({name, ".data_out"}, 64'(data_out), 64'(m_dout));
        check({name, ".read_valid"}, 64'(read_valid), 64'(m_rv));
    endtask

    // Drive one bus cycle, advance the model at the edge, sample after it
    task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w, input logic r);
        @(negedge clock);
        address = a; data_in = d; write = w; read = r;
        @(posedge clock);
        model_step(a, d, w, r);
        #1;
    endtask

    task automatic idle();
        step(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; write = 1'b0; read = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  d;
        logic        w;
        logic [31:0] exp_port;
        logic [3:0]  exp_upd;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{8'hE1, 8'hA5, 1'b1, 32'h0000A500, 4'b0010};
        vecs[1]  = '{8'h00, 8'h00, 1'b0, 32'h0000A500, 4'b0000};
        vecs[2]  = '{8'hE5, 8'h0F, 1'b1, 32'h0000AF00, 4'b0010};
        vecs[3]  = '{8'hE9, 8'hA0, 1'b1, 32'h00000F00, 4'b0010};
        vecs[4]  = '{8'hED, 8'hFF, 1'b1, 32'h0000F000, 4'b0010};
        vecs[5]  = '{8'hF1, 8'hDF, 1'b1, 32'h0000F000, 4'b0000};
        vecs[6]  = '{8'hF5, 8'h11, 1'b1, 32'h0000F000, 4'b0000};
        vecs[7]  = '{8'hE1, 8'hF0, 1'b1, 32'h0000F000, 4'b0010};
        vecs[8]  = '{8'hEC, 8'h01, 1'b1, 32'h0000F001, 4'b0001};
        vecs[9]  = '{8'hE3, 8'h80, 1'b1, 32'h8000F001, 4'b1000};
        vecs[10] = '{8'hEB, 8'hFF, 1'b1, 32'h0000F001, 4'b1000};
        vecs[11] = '{8'hE6, 8'h30, 1'b1, 32'h0030F001, 4'b0100};
        vecs[12] = '{8'hDF, 8'hFF, 1'b1, 32'h0030F001, 4'b0000};

        model_reset();
        #2;
        check("reset.port_out", 64'(port_out), 64'h0);
        check("reset.port_update", 64'(port_update), 64'h0);
        check("reset.data_out", 64'(data_out), 64'h0);
        check("reset.read_valid", 64'(read_valid), 64'h0);
        do_reset();

        // Directed vector table
        for (int v = 0; v < 13; v++) begin
            step(vecs[v].a, vecs[v].d, vecs[v].w, 1'b0);
            check($sformatf("vec%0d.port_out", v), 64'(port_out), 64'(vecs[v].exp_port));
            check($sformatf("vec%0d.port_update", v), 64'(port_update), 64'(vecs[v].exp_upd));
        end

        // Pulse mode: value held for exactly C_PULSE cycles, silent clear
        step(8'hF0, 8'h01, 1'b1, 1'b0);
        check("ctrl_wr.port_update", 64'(port_update), 64'h0);
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        check("pulse.first", 64'(port_out[7:0]), 64'h3C);
        for (int c = 1; c < C_PULSE; c++) begin
            idle();
            check($sformatf("pulse.hold%0d", c), 64'(port_out[7:0]), 64'h3C);
        end
        idle();
        check("pulse.cleared", 64'(port_out[7:0]), 64'h00);
        check("pulse.no_strobe", 64'(port_update), 64'h0);

        // Rewrite two cycles in extends the pulse
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        idle();
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        check("extend.strobe", 64'(port_update), 64'h1);
        for (int c = 1; c < C_PULSE; c++) begin
            idle();
            check($sformatf("extend.hold%0d", c), 64'(port_out[7:0]), 64'h3C);
        end
        idle();
        check("extend.cleared", 64'(port_out[7:0]), 64'h00);

        // Write landing on the expiry edge wins and reloads
        step(8'hE0, 8'h55, 1'b1, 1'b0);
        repeat (C_PULSE - 1) idle();
        step(8'hE0, 8'h66, 1'b1, 1'b0);
        check("expiry_write.value", 64'(port_out[7:0]), 64'h66);
        repeat (C_PULSE - 1) idle();
        check("expiry_write.hold", 64'(port_out[7:0]), 64'h66);
        idle();
        check("expiry_write.cleared", 64'(port_out[7:0]), 64'h00);

        // Clearing CTRL mid-pulse freezes the value
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        idle();
        step(8'hF0, 8'h00, 1'b1, 1'b0);
        repeat (C_PULSE + 1) idle();
        check("ctrl_clear.frozen", 64'(port_out[7:0]), 64'h3C);

        // Setting CTRL alone starts no timer
        step(8'hF0, 8'h01, 1'b1, 1'b0);
        repeat (C_PULSE + 2) idle();
        check("ctrl_set.no_timer", 64'(port_out[7:0]), 64'h3C);

        // Zero write in pulse mode still strobes
        step(8'hE0, 8'h00, 1'b1, 1'b0);
        check("zero_write.strobe", 64'(port_update), 64'h1);
        check_model("zero_write");

        // Asynchronous reset mid-pulse (timer at 2)
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        idle();
        idle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midreset.port_out", 64'(port_out), 64'h0);
        check("midreset.port_update", 64'(port_update), 64'h0);
        check("midreset.data_out", 64'(data_out), 64'h0);
        check("midreset.read_valid", 64'(read_valid), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (C_PULSE + 1) idle();
        check("midreset.after", 64'(port_out), 64'h0);
        step(8'hE0, 8'h3C, 1'b1, 1'b0);
        repeat (C_PULSE + 1) idle();
        check("midreset.ctrl_cleared", 64'(port_out[7:0]), 64'h3C);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ra, rd;
            logic       rw, rr;
            ra = 8'($urandom_range(8'hF3, 8'hDC));
            rd = 8'($urandom);
            rw = ($urandom_range(1, 0) == 1);
            rr = ($urandom_range(2, 0) == 0);
            step(ra, rd, rw, rr);
            check_model($sformatf("rand%0d", n));
        end

        // Readback
        do_reset();
        step(8'hE1, 8'hA5, 1'b1, 1'b0);
        step(8'hF0, 8'h01, 1'b1, 1'b0);
        step(8'hE1, 8'h00, 1'b0, 1'b1);
`ifdef OUTPUT_PORT_BANK_READBACK_EN
        check("rb_e1.data_out", 64'(data_out), 64'hA5);
        check("rb_e1.read_valid", 64'(read_valid), 64'h1);
        step(8'hF0, 8'h00, 1'b0, 1'b1);
        check("rb_f0.data_out", 64'(data_out), 64'h01);
        step(8'hE5, 8'h00, 1'b0, 1'b1);
        check("rb_set.data_out", 64'(data_out), 64'h00);
        check("rb_set.read_valid", 64'(read_valid), 64'h1);
        step(8'hE1, 8'h00, 1'b1, 1'b1);
        check("rb_same_cycle.data_out", 64'(data_out), 64'hA5);
        check("rb_same_cycle.port", 64'(port_out[15:8]), 64'h00);
        idle();
        check("rb_idle.read_valid", 64'(read_valid), 64'h0);
`else
        check("rb_off.data_out", 64'(data_out), 64'h0);
        check("rb_off.read_valid", 64'(read_valid), 64'h0);
        step(8'hF0, 8'h00, 1'b0, 1'b1);
        check("rb_off_ctrl.data_out", 64'(data_out), 64'h0);
`endif
        check_model("rb_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
